// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_pkg
//  Description : Shared types and constants for the data memory block.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    // Width of one stored word and of the byte address bus.
    localparam int DATA_W        = 32;

    // Default number of words held by the memory.
    localparam int DEPTH_DEFAULT = 256;

    // One memory word.
    typedef logic [DATA_W-1:0] word_t;

    // True when n is a non-zero power of two.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/data_mem_addr_dec.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_addr_dec
//  Description : Splits a byte address into a word index and an in-range
//                flag. The two byte-offset bits are dropped so every access
//                is word aligned; any set bit above the index field marks the
//                address as out of range.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_addr_dec
    import data_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DATA_W-1:0] i_addr,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_in_range
);

    // Byte-offset bits carry no meaning for a word-organised memory.
    logic [1:0] w_unused_offset;
    assign w_unused_offset = i_addr[1:0];

    // Index field sits directly above the byte offset; anything higher must be zero.
    always_comb begin
        o_idx      = i_addr[IDX_W+1:2];
        o_in_range = ~|i_addr[DATA_W-1:IDX_W+2];
    end

endmodule : data_mem_addr_dec
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem
//  Description : Word-organised data memory with combinational, zero-latency
//                read and rising-edge write. Out-of-range accesses read zero
//                and writes to them are dropped. An asynchronous active-low
//                reset clears every word.
//
//                Optional feature (compile-time macro):
//                  DATA_MEM_VERIFY_EN - when defined, 'verify' mirrors word
//                  VERIFY_IDX; when undefined, 'verify' is tied to zero.
//                The port list is the same in both builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEFAULT,
    parameter int VERIFY_IDX = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] addr,
    input  word_t             data_i,
    output word_t             data_o,
    output word_t             verify
);

    localparam int c_IDX_W = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (!is_pow2(DEPTH) || (DEPTH < 4)) begin : g_bad_depth
        $error("data_mem: DEPTH must be a power of two and at least 4");
    end

    if ((VERIFY_IDX < 0) || (VERIFY_IDX >= DEPTH)) begin : g_bad_verify_idx
        $error("data_mem: VERIFY_IDX must address an existing word");
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0] w_idx;
    logic               w_in_range;
    logic               w_wr_en;

    data_mem_addr_dec #(
        .DEPTH (DEPTH),
        .IDX_W (c_IDX_W)
    ) u_addr_dec (
        .i_addr     (addr),
        .o_idx      (w_idx),
        .o_in_range (w_in_range)
    );

    // Only a definite 1 on 'we' together with an in-range address commits.
    assign w_wr_en = we & w_in_range;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    word_t r_mem [DEPTH];

    // Async clear of every word; otherwise commit a qualified write on the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_idx] <= data_i;
        end
    end

    // Zero-latency load: no write bypass, so a same-word write shows only after the edge.
    always_comb begin
        data_o = w_in_range ? r_mem[w_idx] : '0;
    end

    // ------------------------------------------------------------------
    // Observation port
    // ------------------------------------------------------------------
`ifdef DATA_MEM_VERIFY_EN
    localparam logic [c_IDX_W-1:0] c_VERIFY_IDX = c_IDX_W'(VERIFY_IDX);

    // Continuous mirror of the selected word for debug visibility.
    always_comb begin
        verify = r_mem[c_VERIFY_IDX];
    end
`else
    // Mirror not built: keep the port present but constant.
    always_comb begin
        verify = '0;
    end

    logic [31:0] w_unused_cfg;
    assign w_unused_cfg = 32'(VERIFY_IDX);
`endif

endmodule : data_mem
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem
//  Description : Self-checking bench for data_mem. A plain array model is
//                updated from the behavioural rules (word address = byte
//                address / 4, out-of-range when address >= 4*DEPTH) and
//                compared against the DUT before and after every edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem;

    localparam int DEPTH      = 256;
    localparam int VERIFY_IDX = 0;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [31:0] verify;

    int n_checks;
    int n_pass;

    logic [31:0] model [DEPTH];

    data_mem #(
        .DEPTH      (DEPTH),
        .VERIFY_IDX (VERIFY_IDX)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .addr   (addr),
        .data_i (data_i),
        .data_o (data_o),
        .verify (verify)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit in_range(input logic [31:0] a);
        return a < (DEPTH * 4);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (!in_range(a)) return 32'h0;
        return model[a / 4];
    endfunction

    function automatic logic [31:0] ref_verify();
`ifdef DATA_MEM_VERIFY_EN
        return model[VERIFY_IDX];
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive an address, let it settle, and compare load data and mirror.
    task automatic rd_chk(input string tag, input logic [31:0] a);
        addr = a;
        #1;
        chk({tag, "_data"}, data_o, ref_read(a));
        chk({tag, "_verify"}, verify, ref_verify());
    endtask

    // One write cycle with checks before and after the edge.
    task automatic do_write(input string tag, input logic [31:0] a,
                            input logic [31:0] d, input logic w);
        @(negedge clk);
        we     = w;
        addr   = a;
        data_i = d;
        #1;
        chk({tag, "_pre"}, data_o, ref_read(a));
        @(posedge clk);
        if (w === 1'b1 && in_range(a)) model[a / 4] = d;
        #1;
        we = 1'b0;
        chk({tag, "_post"}, data_o, ref_read(a));
        chk({tag, "_vfy"}, verify, ref_verify());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        logic        rw;

        n_checks = 0;
        n_pass   = 0;
        model_clear();

        rst    = 1'b0;
        we     = 1'b0;
        addr   = 32'h0;
        data_i = 32'h0;
        #1;

        // Reset state reads zero everywhere.
        rd_chk("rst_0x0",   32'h0);
        rd_chk("rst_0x4",   32'h4);
        rd_chk("rst_0x3fc", 32'h3FC);

        // A write edge while in reset must be ignored.
        we     = 1'b1;
        addr   = 32'h0;
        data_i = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        we = 1'b0;
        rd_chk("rst_wr_ign", 32'h0);

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rd_chk("post_rst_0", 32'h0);
        rd_chk("post_rst_8", 32'h8);

        // Basic write / word-aligned reads.
        do_write("wr_8", 32'h8, 32'hDEAD_BEEF, 1'b1);
        rd_chk("rd_8", 32'h8);
        rd_chk("rd_9", 32'h9);
        rd_chk("rd_a", 32'hA);
        rd_chk("rd_b", 32'hB);
        chk("rd_b_const", data_o, 32'hDEAD_BEEF);

        // Read during write: old before edge, new after.
        do_write("wr_10a", 32'h10, 32'h11, 1'b1);
        do_write("wr_10b", 32'h10, 32'h22, 1'b1);
        chk("rdw_new", data_o, 32'h22);

        // Mirror of word 0.
        do_write("wr_0", 32'h0, 32'h1234, 1'b1);
`ifdef DATA_MEM_VERIFY_EN
        chk("verify_mirror", verify, 32'h1234);
`else
        chk("verify_tied", verify, 32'h0);
`endif

        // Out-of-range write dropped, no aliasing into word 0.
        do_write("oor_400", 32'h400, 32'h55, 1'b1);
        rd_chk("oor_rd", 32'h400);
        rd_chk("oor_w0", 32'h0);
        chk("oor_w0_const", data_o, 32'h1234);
        do_write("oor_high", 32'h8000_0008, 32'h77, 1'b1);
        rd_chk("oor_w8", 32'h8);

        // Unknown write enable means no write.
        do_write("we_x", 32'h20, 32'hBAD0_BAD0, 1'bx);
        rd_chk("we_x_rd", 32'h20);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) ra = $urandom;
            else                          ra = $urandom & 32'h3FF;
            rd = $urandom;
            rw = 1'($urandom_range(0, 1));
            do_write("rnd", ra, rd, rw);
            rd_chk("rnd_rd", $urandom & 32'h7FF);
        end

        // Asynchronous reset between edges.
        do_write("pre_arst", 32'h8, 32'hCAFE_F00D, 1'b1);
        do_write("pre_arst0", 32'h0, 32'h0BAD_CAFE, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        rd_chk("arst_8", 32'h8);
        rd_chk("arst_0", 32'h0);
        we     = 1'b1;
        addr   = 32'h8;
        data_i = 32'h1111_2222;
        @(posedge clk);
        #1;
        chk("arst_wr_ign", data_o, 32'h0);
        @(negedge clk);
        we  = 1'b0;
        rst = 1'b1;
        rd_chk("arst_rel_8", 32'h8);

        do_write("final", 32'h3FC, 32'h600D_600D, 1'b1);
        rd_chk("final_rd", 32'h3FC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_data_mem
`default_nettype wire

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
- REQ-001: Parameter DEPTH, default 256, SHALL set the number of 32-bit words stored (power of two, ≥ 4).
- REQ-002: Parameter VERIFY_IDX, default 0, SHALL set the word index mirrored on verify.
- REQ-003: Port clk, input, 1, is the single clock; all writes occur on its rising edge.
- REQ-004: Port rst, input, 1, is the reset: asynchronous, active-low.
- REQ-005: Port we, input, 1, is the write enable.
- REQ-006: Port addr, input, 32, is the byte address (normally the ALU result).
- REQ-007: Port data_i, input, 32, is the store data (normally register rs2 read data).
- REQ-008: Port data_o, output, 32, is the load data.
- REQ-009: Port verify, output, 32, is the debug/observation copy of word VERIFY_IDX.

Function
- REQ-010: Word index SHALL be addr[log2(DEPTH)+1:2]; addr[1:0] SHALL be ignored, so all accesses are word-aligned.
- REQ-011: An address is in range when addr[31:log2(DEPTH)+2] == 0; otherwise it is out of range.
- REQ-012: data_o SHALL be combinational: mem[index] for in-range addresses, 32'h0 for out-of-range addresses, zero latency.
- REQ-013: A write SHALL occur on rising clk only when rst = 1, we = 1 and addr is in range: mem[index] <= data_i.
- REQ-014: Out-of-range writes SHALL be silently dropped, with no aliasing into any word.
- REQ-015: Read during write to the same word: data_o SHALL show the old value before the edge and the new value after it; no bypass.
- REQ-016: Writes to other words SHALL leave all other words unchanged.
- REQ-017: verify SHALL combinationally equal mem[VERIFY_IDX] whenever the feature of REQ-022 is compiled in.
- REQ-018: X or Z on we SHALL be treated as no write.

Reset
- REQ-019: While rst = 0, all DEPTH words SHALL clear to 0 immediately (asynchronously), and data_o and verify SHALL read 0.
- REQ-020: A write edge coinciding with rst = 0 SHALL be ignored.
- REQ-021: After rst deasserts, contents SHALL stay 0 until the first qualifying write edge.

Configuration
- REQ-022: Macro DATA_MEM_VERIFY_EN defined: verify is driven per REQ-017.
- REQ-023: Macro DATA_MEM_VERIFY_EN undefined: verify SHALL be tied to 32'h0 and no mirror logic is generated.
- REQ-024: The port list SHALL be identical with and without DATA_MEM_VERIFY_EN.

Structure
- REQ-025: Shared package data_mem_pkg SHALL hold DATA_W = 32, the default DEPTH, and a word_t typedef (32-bit logic).
- REQ-026: One sub-module, data_mem_addr_dec, SHALL compute the word index and the in-range flag from addr.
- REQ-027: The storage array and write process SHALL remain in data_mem.

Verification
- REQ-028: Reset: rst = 0, then read addr 0x0, 0x4 and 0x3FC -> data_o = 0 and verify = 0 for each.
- REQ-029: Write/read: we = 1, addr = 0x8, data_i = 0xDEADBEEF, one edge; then we = 0 -> data_o = 0xDEADBEEF at addr 0x8, 0x9, 0xA and 0xB.
- REQ-030: Read during write: addr = 0x10 holds 0x11, write 0x22 -> data_o = 0x11 before the edge and 0x22 after it.
- REQ-031: Out of range (DEPTH = 256): write 0x55 to addr 0x400 -> data_o = 0 at 0x400, and word 0 remains unchanged.
- REQ-032: Verify mirror (VERIFY_IDX = 0, macro defined): write 0x1234 to addr 0x0 -> verify = 0x1234; with macro undefined -> verify = 0.
- REQ-033: Async reset mid-operation: assert rst = 0 between clock edges after writes -> data_o and verify drop to 0 before the next edge, and a we = 1 edge during reset writes nothing.
